// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and step-counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold 0..n-1 but never collapse to zero bits when n == 1.
  function automatic int step_cnt_width(input int n);
    int w;
    w = $clog2(n);
    step_cnt_width = (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells: diff = a - b - bin, bout = borrow-out.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);

  // Unpacked chain keeps each borrow a separate signal along the ripple.
  logic brw [DIGIT+1];

  assign brw[0] = bin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
    assign diff[gi]    = a[gi] ^ b[gi] ^ brw[gi];
    assign brw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & brw[gi]);
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, DIGIT bits per cycle LSB first, valid/ready on both sides.
// Define SERIAL_SUB_FLAGS_EN to add registered zero and signed-overflow outputs.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  import serial_sub_pkg::*;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = step_cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             brw_reg;
  logic [CW-1:0]    cnt_reg;

  logic [DIGIT-1:0] dig;
  logic             dig_bout;
  logic [WIDTH-1:0] diff_shift;
  logic             accept;
  logic             step;
  logic             last;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_reg == LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        // Consuming the result frees the slot in the same cycle, so a waiting
        // operand can be taken without an idle bubble.
        in_ready  = out_ready;
        if (out_ready) begin
          state_next = in_valid ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;
  assign step   = (state_reg == ST_RUN);
  assign last   = step && (cnt_reg == LAST);

  // ---------------------------------------------------------------- datapath
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_reg[DIGIT-1:0]),
    .b    (b_reg[DIGIT-1:0]),
    .bin  (brw_reg),
    .diff (dig),
    .bout (dig_bout)
  );

  // Result digits enter at the MSB end so after N steps the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_shift_full
    assign diff_shift = dig;
  end else begin : g_shift_part
    assign diff_shift = {dig, diff_reg[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      brw_reg  <= 1'b0;
      cnt_reg  <= '0;
    end else if (accept) begin
      a_reg    <= a;
      b_reg    <= b;
      brw_reg  <= bin;
      cnt_reg  <= '0;
    end else if (step) begin
      a_reg    <= a_reg >> DIGIT;
      b_reg    <= b_reg >> DIGIT;
      diff_reg <= diff_shift;
      brw_reg  <= dig_bout;
      cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  assign diff   = diff_reg;
  assign borrow = brw_reg;

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb_reg;
  logic b_msb_reg;
  logic zero_reg;
  logic ovf_reg;

  // Overflow only when operand signs differ and the result sign leaves the minuend's.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if (last) begin
      zero_reg  <= (diff_shift == '0);
      ovf_reg   <= (a_msb_reg != b_msb_reg) && (diff_shift[WIDTH-1] != a_msb_reg);
    end
  end

  assign zero = zero_reg;
  assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: four instances (8/1, 8/4, 16/4, 1/1) checked against an arithmetic model.
module tb_serial_subtractor;

  localparam int NDUT = 4;
  localparam int WID [NDUT] = '{8, 8, 16, 1};
  localparam int DIG [NDUT] = '{1, 4, 4, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic        in_valid_v  [NDUT];
  logic        out_ready_v [NDUT];
  logic        bin_v       [NDUT];
  logic [15:0] a_v         [NDUT];
  logic [15:0] b_v         [NDUT];

  wire         in_ready_w  [NDUT];
  wire         out_valid_w [NDUT];
  wire         borrow_w    [NDUT];
  wire         busy_w      [NDUT];
  wire  [15:0] diff_w      [NDUT];
`ifdef SERIAL_SUB_FLAGS_EN
  wire         zero_w      [NDUT];
  wire         ovf_w       [NDUT];
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int W = WID[gi];
    localparam int D = DIG[gi];
    serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_w[gi]),
      .a         (a_v[gi][W-1:0]),
      .b         (b_v[gi][W-1:0]),
      .bin       (bin_v[gi]),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready_v[gi]),
      .diff      (diff_w[gi][W-1:0]),
      .borrow    (borrow_w[gi]),
      .busy      (busy_w[gi])
`ifdef SERIAL_SUB_FLAGS_EN
      ,
      .zero      (zero_w[gi]),
      .ovf       (ovf_w[gi])
`endif
    );
    if (W < 16) begin : g_pad
      assign diff_w[gi][15:W] = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] msk(input int k);
    msk = 16'((32'd1 << WID[k]) - 1);
  endfunction

  // Reference: {borrow,diff} is the (WIDTH+1)-bit value of a - b - bin.
  function automatic int unsigned model_full(input int k, input int unsigned a, input int unsigned b, input bit bi);
    model_full = (a - b - bi) & ((32'd1 << (WID[k] + 1)) - 1);
  endfunction

  function automatic bit model_ovf(input int k, input int unsigned a, input int unsigned b, input bit bi);
    int w, sa, sb, t;
    w  = WID[k];
    sa = (a >= (32'd1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb = (b >= (32'd1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    t  = sa - sb - int'(bi);
    model_ovf = (t < -(1 << (w - 1))) || (t > (1 << (w - 1)) - 1);
  endfunction

  // Drive one operation on instance k, wait for the result, then consume it.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic bi,
                        output logic [15:0] d, output logic br, output int lat,
                        output logic zf, output logic of, output bit to);
    int t;
    int c0;
    to = 0; d = '0; br = 0; lat = 0; zf = 0; of = 0;
    @(negedge clk);
    a_v[k] = a & msk(k); b_v[k] = b & msk(k); bin_v[k] = bi;
    in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b0;
    #1;
    t = 0;
    while (!in_ready_w[k] && t < 50) begin @(negedge clk); #1; t++; end
    if (!in_ready_w[k]) begin to = 1; in_valid_v[k] = 1'b0; return; end
    c0 = cyc;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    a_v[k] = 16'($urandom) & msk(k); b_v[k] = 16'($urandom) & msk(k); bin_v[k] = 1'($urandom);
    #1;
    t = 0;
    while (!out_valid_w[k] && t < 50) begin @(negedge clk); #1; t++; end
    if (!out_valid_w[k]) begin to = 1; return; end
    lat = cyc - c0;
    d   = diff_w[k];
    br  = borrow_w[k];
`ifdef SERIAL_SUB_FLAGS_EN
    zf  = zero_w[k];
    of  = ovf_w[k];
`endif
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NDUT; k++) begin
      tests_run += 4;
      if (out_valid_w[k] !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid_w[k]); end
      if (busy_w[k] !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy_w[k]); end
      if (diff_w[k] !== 16'h0)     begin tests_failed++; $display("FAIL reset_diff[%0d]: got %h want 0", k, diff_w[k]); end
      if (borrow_w[k] !== 1'b0)    begin tests_failed++; $display("FAIL reset_borrow[%0d]: got %b want 0", k, borrow_w[k]); end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      tests_run++;
      if (in_ready_w[k] !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready_w[k]); end
    end
  endtask

  task automatic test_basic();
    int          kk [7] = '{0, 0, 1, 1, 2, 2, 3};
    logic [15:0] ta [7] = '{16'h05, 16'h00, 16'h10, 16'h80, 16'hFFFF, 16'h8000, 16'h0};
    logic [15:0] tb [7] = '{16'h03, 16'h01, 16'h0F, 16'h01, 16'hFFFF, 16'h0001, 16'h1};
    logic        tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ed [7] = '{16'h02, 16'hFF, 16'h00, 16'h7F, 16'hFFFF, 16'h7FFF, 16'h0};
    logic        eb [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          el [7] = '{9, 9, 3, 3, 5, 5, 2};
    logic        ez [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        eo [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] d;
    logic        br, zf, of;
    int          lat;
    bit          to;
    for (int i = 0; i < 7; i++) begin
      run_op(kk[i], ta[i], tb[i], tc[i], d, br, lat, zf, of, to);
      tests_run++;
      if (to) begin tests_failed++; $display("FAIL basic_timeout[%0d]: handshake did not complete", i); continue; end
      tests_run += 3;
      if (d !== ed[i])    begin tests_failed++; $display("FAIL basic_diff[%0d]: got %h want %h", i, d, ed[i]); end
      if (br !== eb[i])   begin tests_failed++; $display("FAIL basic_borrow[%0d]: got %b want %b", i, br, eb[i]); end
      if (lat !== el[i])  begin tests_failed++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, el[i]); end
`ifdef SERIAL_SUB_FLAGS_EN
      tests_run += 2;
      if (zf !== ez[i])   begin tests_failed++; $display("FAIL basic_zero[%0d]: got %b want %b", i, zf, ez[i]); end
      if (of !== eo[i])   begin tests_failed++; $display("FAIL basic_ovf[%0d]: got %b want %b", i, of, eo[i]); end
`else
      if (ez[i] === 1'bx || eo[i] === 1'bx) $display("[TB] note: flag table entry %0d undefined", i);
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d0;
    logic        b0;
    int          t, c0;
    @(negedge clk);
    a_v[0] = 16'h3C; b_v[0] = 16'h5A; bin_v[0] = 1'b1; in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
    #1;
    tests_run++;
    if (in_ready_w[0] !== 1'b1) begin tests_failed++; $display("FAIL bp_idle_ready: got %b want 1", in_ready_w[0]); end
    @(negedge clk);
    a_v[0] = 16'h77; b_v[0] = 16'h12; bin_v[0] = 1'b0;
    #1;
    t = 0;
    while (!out_valid_w[0] && t < 50) begin @(negedge clk); #1; t++; end
    tests_run++;
    if (!out_valid_w[0]) begin tests_failed++; $display("FAIL bp_timeout: out_valid never rose"); in_valid_v[0] = 1'b0; return; end
    d0 = diff_w[0]; b0 = borrow_w[0];
    tests_run++;
    if ({b0, d0[7:0]} !== 9'h1E1) begin tests_failed++; $display("FAIL bp_result: got %h want 1e1", {b0, d0[7:0]}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests_run += 4;
      if (out_valid_w[0] !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid_w[0]); end
      if (in_ready_w[0] !== 1'b0)  begin tests_failed++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready_w[0]); end
      if (diff_w[0] !== d0)        begin tests_failed++; $display("FAIL bp_hold_diff[%0d]: got %h want %h", i, diff_w[0], d0); end
      if (borrow_w[0] !== b0)      begin tests_failed++; $display("FAIL bp_hold_borrow[%0d]: got %b want %b", i, borrow_w[0], b0); end
    end
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    #1;
    tests_run++;
    if (in_ready_w[0] !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b want 1", in_ready_w[0]); end
    c0 = cyc;
    @(negedge clk);
    in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b0;
    #1;
    tests_run += 2;
    if (out_valid_w[0] !== 1'b0) begin tests_failed++; $display("FAIL b2b_valid_drop: got %b want 0", out_valid_w[0]); end
    if (busy_w[0] !== 1'b1)      begin tests_failed++; $display("FAIL b2b_busy: got %b want 1", busy_w[0]); end
    t = 0;
    while (!out_valid_w[0] && t < 50) begin @(negedge clk); #1; t++; end
    tests_run += 2;
    if (cyc - c0 !== 9) begin tests_failed++; $display("FAIL b2b_latency: got %0d want 9", cyc - c0); end
    if ({borrow_w[0], diff_w[0][7:0]} !== 9'h065) begin tests_failed++; $display("FAIL b2b_result: got %h want 065", {borrow_w[0], diff_w[0][7:0]}); end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] d;
    logic        br, zf, of;
    int          lat;
    bit          to;
    @(negedge clk);
    a_v[0] = 16'hF0; b_v[0] = 16'h0F; bin_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (busy_w[0] !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy_before: got %b want 1", busy_w[0]); end
    #2 rst = 1'b1;
    #1;
    tests_run += 4;
    if (out_valid_w[0] !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b want 0", out_valid_w[0]); end
    if (busy_w[0] !== 1'b0)      begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", busy_w[0]); end
    if (diff_w[0] !== 16'h0)     begin tests_failed++; $display("FAIL midrst_diff: got %h want 0", diff_w[0]); end
    if (borrow_w[0] !== 1'b0)    begin tests_failed++; $display("FAIL midrst_borrow: got %b want 0", borrow_w[0]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready_w[0] !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b want 1", in_ready_w[0]); end
    run_op(0, 16'h09, 16'h04, 1'b0, d, br, lat, zf, of, to);
    tests_run += 3;
    if (to) begin tests_failed++; $display("FAIL midrst_timeout: operation did not complete"); end
    if ({br, d} !== 17'h00005) begin tests_failed++; $display("FAIL midrst_result: got %h want 00005", {br, d}); end
    if (lat !== 9) begin tests_failed++; $display("FAIL midrst_latency: got %0d want 9", lat); end
  endtask

  task automatic test_random();
    for (int k = 0; k < NDUT; k++) begin
      int unsigned exp_q [$];
      int          sent;
      int          got;
      int          budget;
      bit          took;
      int unsigned e, full, want_d, want_b;
      sent = 0; got = 0; budget = 0; took = 0;
      while (got < 250 && budget < 20000) begin
        @(negedge clk);
        if (took) in_valid_v[k] = 1'b0;
        if (!in_valid_v[k]) begin
          if (sent < 250 && $urandom_range(3) != 0) begin
            a_v[k] = 16'($urandom) & msk(k); b_v[k] = 16'($urandom) & msk(k); bin_v[k] = 1'($urandom);
            in_valid_v[k] = 1'b1;
          end else begin
            a_v[k] = 16'($urandom) & msk(k); b_v[k] = 16'($urandom) & msk(k); bin_v[k] = 1'($urandom);
          end
        end
        out_ready_v[k] = ($urandom_range(3) != 0);
        #1;
        took = in_valid_v[k] && in_ready_w[k];
        if (out_valid_w[k] && out_ready_v[k]) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++; $display("FAIL rand_unexpected[%0d]: result with no operation outstanding", k);
          end else begin
            e      = exp_q.pop_front();
            full   = e & 32'h1FFFF;
            want_d = full & msk(k);
            want_b = (full >> WID[k]) & 1;
            if (diff_w[k] !== 16'(want_d) || borrow_w[k] !== 1'(want_b)) begin
              tests_failed++;
              $display("FAIL rand_result[%0d] op %0d: got borrow=%b diff=%h want borrow=%0d diff=%h", k, got, borrow_w[k], diff_w[k], want_b, want_d);
            end
`ifdef SERIAL_SUB_FLAGS_EN
            tests_run++;
            if (zero_w[k] !== (want_d == 0) || ovf_w[k] !== 1'((e >> 20) & 1)) begin
              tests_failed++;
              $display("FAIL rand_flags[%0d] op %0d: got zero=%b ovf=%b want zero=%0d ovf=%0d", k, got, zero_w[k], ovf_w[k], want_d == 0, (e >> 20) & 1);
            end
`endif
          end
          got++;
        end
        if (took) begin
          exp_q.push_back(model_full(k, a_v[k], b_v[k], bin_v[k]) |
                          (int'(model_ovf(k, a_v[k], b_v[k], bin_v[k])) << 20));
          sent++;
        end
        budget++;
      end
      tests_run++;
      if (got < 250) begin tests_failed++; $display("FAIL rand_timeout[%0d]: only %0d of 250 results", k, got); end
      @(negedge clk);
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0; bin_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
